uart_rx_core: RTL and testbench
===============================

# uart_rx_core

UART receive stage that consumes the serial line produced by the transmit stage (`ser_out`). It uses the `en_rx` strobe from the shared clock generator (16x baud) to oversample the line, frame start/data/stop bits and deserialize one byte. It holds that byte in a one-entry output register with a valid/ack handshake. Framing and overrun errors are reported as one-cycle pulses.

## Interface
- `OVERSAMPLE`, default 16: `en_rx` strobes per bit period. Fixed at 16 for this revision.
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en_rx`  in  1  one-`clk` strobe at 16x baud from the clock generator.
- `ser_in`  in  1  asynchronous serial line; idles high.
- `dout_byte`  out  DATA_BITS  received byte; valid while `dout_valid`=1.
- `dout_valid`  out  1  holding register full.
- `dout_ack`  in  1  consumer takes the byte; sampled only when `dout_valid`=1.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: byte completed while the register was still full.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- `ser_in` passes through a 2-FF synchronizer. The synchronizer resets to 1.
- The FSM has four states: IDLE, START, DATA, STOP. A 4-bit tick counter advances only on `en_rx`, and all FSM and sample updates qualify on `en_rx`.
- IDLE: on an `en_rx` where the synchronized line is 0, clear the tick counter to 0 and go to START.
- Sampling, all states: take the line at ticks 7, 8 and 9 and resolve each bit by 2-of-3 majority.
- START: at tick 15, a majority of 0 goes to DATA with the bit index at 0. A majority of 1 is a false start and returns to IDLE with no error flag.
- DATA: at tick 15, shift the majority bit into the MSB of the shift register (LSB-first line order). After bit index 7, go to STOP.
- STOP: decide at tick 9, not 15, so the FSM can resync early on back-to-back frames.
  - Majority of 1: deliver the byte.
  - Majority of 0: pulse `frame_err` and discard the byte.
  - Either outcome returns to IDLE.
- Delivery when `dout_valid`=0, or `dout_ack`=1 in the same cycle: load `dout_byte` and set `dout_valid`=1.
- Delivery when `dout_valid`=1 and no ack: drop the new byte, keep the old one, and pulse `overrun_err`.
- `dout_ack` with `dout_valid`=1 and no delivery in the same cycle clears `dout_valid`. `dout_byte` keeps its value.
- Ack while `dout_valid`=0 is ignored.
- The tick counter wraps 15→0 naturally. There is no saturation.

## Timing
- Reset values: `dout_byte`=0x00, `dout_valid`=0, `frame_err`=0, `overrun_err`=0, `rx_busy`=0, FSM=IDLE, tick counter=0, shift register=0.
- Reset mid-frame: asynchronously returns to IDLE and drops the partial byte. The holding register is cleared.
- `ser_in` to the synchronized line: 2 `clk`.
- Delivery: `dout_valid`, `frame_err` and `overrun_err` update on the same edge as the STOP tick-9 `en_rx`. `rx_busy` falls on that edge too.
- `frame_err` and `overrun_err` are exactly one `clk` wide, independent of `en_rx` spacing.
- Frame length, start-edge detection to delivery: 9×16 + 10 `en_rx` strobes, ±1 strobe of edge-detection uncertainty.
- `en_rx` may arrive on consecutive clocks. There is no minimum spacing.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `rx_state_t` {IDLE, START, DATA, STOP};
  - `OVERSAMPLE`, `MID_TICK`=8, `LAST_TICK`=15;
  - the default for `DATA_BITS`.
- Sub-module `uart_rx_sync` is the 2-FF synchronizer with a reset value parameter.
- Everything else stays in one module: FSM, tick and bit counters, majority vote, shift register and holding register.

## Test plan
- In all scenarios the bench drives `en_rx` every 4 `clk` and serializes 16 strobes per bit.
- Frame 0x55 with a good stop bit → `dout_byte`=0x55, `dout_valid`=1, no error pulses. Then `dout_ack` → `dout_valid`=0.
- Frames 0xA3 then 0x0F back-to-back, with no ack → 0xA3 is held, `overrun_err` pulses once, `dout_byte` stays 0xA3.
- Frame 0xC4 with the stop bit forced to 0 → `frame_err` pulses 1 cycle, `dout_valid` stays 0.
- A 5-strobe low glitch on an idle line → false start, back to IDLE, no outputs change.
- Frame 0x81 with a 1-strobe inverted glitch at tick 8 of bit 3 → majority still gives 0x81.
- `rst_n` asserted in the middle of DATA, then a clean frame 0x3C → all outputs at reset values after reset, then 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, oversampling
// constants, default frame width and a 2-of-3 majority helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 8;
  localparam int unsigned LAST_TICK  = 15;
  localparam int unsigned DATA_BITS  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronized out).
// RESET_VAL sets the value both flops take in reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled start/data/stop framing with 2-of-3
// majority voting at ticks 7/8/9, LSB-first deserialization and a
// one-entry output register with valid/ack handshake.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   en_rx            16x baud strobe
//   ser_in           async serial line (idles high)
//   dout_byte/valid  holding register and its full flag
//   dout_ack         consumer takes the byte (only when valid)
//   frame_err        1-cycle pulse, stop bit sampled low
//   overrun_err      1-cycle pulse, byte completed while register full
//   rx_busy          FSM not in IDLE
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int unsigned DATA_BITS  = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_rx,
  input  logic                 ser_in,
  output logic [DATA_BITS-1:0] dout_byte,
  output logic                 dout_valid,
  input  logic                 dout_ack,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] T_S0   = TICK_W'(MID_TICK - 1);
  localparam logic [TICK_W-1:0] T_S1   = TICK_W'(MID_TICK);
  localparam logic [TICK_W-1:0] T_S2   = TICK_W'(MID_TICK + 1);
  localparam logic [TICK_W-1:0] T_LAST = TICK_W'(LAST_TICK);
  localparam logic [BIT_W-1:0]  B_LAST = BIT_W'(DATA_BITS - 1);

  rx_state_t             state, state_nxt;
  logic                  line;
  logic [TICK_W-1:0]     tick;
  logic [BIT_W-1:0]      bit_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic [1:0]            samp;
  logic                  bit_q;
  logic                  vote;
  logic                  deliver;
  logic                  fe_nxt;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ser_in),
    .q     (line)
  );

  // Third sample is the live line at tick 9; STOP decides on it directly.
  assign vote    = maj3(samp[0], samp[1], line);
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    fe_nxt    = 1'b0;
    if (en_rx) begin
      unique case (state)
        IDLE:  if (!line) state_nxt = START;
        START: if (tick == T_LAST) state_nxt = bit_q ? IDLE : DATA;
        DATA:  if (tick == T_LAST && bit_idx == B_LAST) state_nxt = STOP;
        STOP: begin
          if (tick == T_S2) begin
            state_nxt = IDLE;
            deliver   = vote;
            fe_nxt    = !vote;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      samp    <= '0;
      bit_q   <= 1'b0;
    end else if (en_rx) begin
      if (state == IDLE) tick <= '0;
      else               tick <= tick + 1'b1;

      if (state != IDLE) begin
        if (tick == T_S0) samp[0] <= line;
        if (tick == T_S1) samp[1] <= line;
        if (tick == T_S2) bit_q   <= vote;
      end

      if (state == START) bit_idx <= '0;
      if (state == DATA && tick == T_LAST) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {bit_q, shreg[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_byte   <= '0;
      dout_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= fe_nxt;
      overrun_err <= deliver && dout_valid && !dout_ack;
      if (deliver && (!dout_valid || dout_ack)) begin
        dout_byte  <= shreg;
        dout_valid <= 1'b1;
      end else if (dout_ack && dout_valid) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_rx;
  logic       ser_in;
  logic [7:0] dout_byte;
  logic       dout_valid;
  logic       dout_ack;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  int checks = 0;
  int passed = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;

  uart_rx_core #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_rx       (en_rx),
    .ser_in      (ser_in),
    .dout_byte   (dout_byte),
    .dout_valid  (dout_valid),
    .dout_ack    (dout_ack),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // en_rx: one clk high out of every four
  initial begin
    en_rx = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      en_rx = 1'b1;
      @(negedge clk);
      en_rx = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (frame_err)   fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (rx_busy)     busy_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic strobe();
    do @(posedge clk); while (!en_rx);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int glitch);
    for (int i = 0; i < 16; i++) begin
      ser_in = (i == glitch) ? ~v : v;
      strobe();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit);
    send_bit(1'b0, -1);
    for (int b = 0; b < 8; b++) send_bit(d[b], (b == gbit) ? 9 : -1);
    send_bit(stop, -1);
  endtask

  task automatic idle(input int n);
    ser_in = 1'b1;
    repeat (n) strobe();
  endtask

  task automatic do_ack();
    @(negedge clk);
    dout_ack = 1'b1;
    @(negedge clk);
    dout_ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gbit;
    int         idle_after;
    logic       ack;
    logic [7:0] exp_byte;
    logic       exp_valid;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int fe0, ov0, bz0;

    vecs[0] = '{8'h55, 1'b1, -1,  4, 1'b1, 8'h55, 1'b1, 0, 0};
    vecs[1] = '{8'hA3, 1'b1, -1,  0, 1'b0, 8'hA3, 1'b1, 0, 0};
    vecs[2] = '{8'h0F, 1'b1, -1,  4, 1'b1, 8'hA3, 1'b1, 0, 1};
    vecs[3] = '{8'hC4, 1'b0, -1, 24, 1'b0, 8'hA3, 1'b0, 1, 0};
    vecs[4] = '{8'h81, 1'b1,  3,  4, 1'b1, 8'h81, 1'b1, 0, 0};

    rst_n = 1'b0; ser_in = 1'b1; dout_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte",  int'(dout_byte), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_busy",  int'(rx_busy), 0);
    check("rst_fe",    int'(frame_err), 0);
    check("rst_ov",    int'(overrun_err), 0);
    rst_n = 1'b1;
    idle(10);

    for (int v = 0; v < 5; v++) begin
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].gbit);
      idle(vecs[v].idle_after);
      check($sformatf("v%0d_byte", v),  int'(dout_byte), int'(vecs[v].exp_byte));
      check($sformatf("v%0d_valid", v), int'(dout_valid), int'(vecs[v].exp_valid));
      check($sformatf("v%0d_busy", v),  int'(rx_busy), 0);
      check($sformatf("v%0d_fe", v),    fe_cnt - fe0, vecs[v].exp_fe);
      check($sformatf("v%0d_ov", v),    ov_cnt - ov0, vecs[v].exp_ov);
      if (vecs[v].ack) begin
        do_ack();
        check($sformatf("v%0d_ack_valid", v), int'(dout_valid), 0);
        check($sformatf("v%0d_ack_byte", v),  int'(dout_byte), int'(vecs[v].exp_byte));
      end
    end

    // Ack while empty is ignored
    do_ack();
    check("ack_empty_valid", int'(dout_valid), 0);

    // Short low glitch on idle line: false start
    fe0 = fe_cnt; ov0 = ov_cnt; bz0 = busy_cnt;
    ser_in = 1'b0;
    repeat (5) strobe();
    idle(30);
    check("glitch_busy_seen", int'(busy_cnt > bz0), 1);
    check("glitch_busy",      int'(rx_busy), 0);
    check("glitch_valid",     int'(dout_valid), 0);
    check("glitch_byte",      int'(dout_byte), 8'h81);
    check("glitch_fe",        fe_cnt - fe0, 0);
    check("glitch_ov",        ov_cnt - ov0, 0);

    // Reset in the middle of DATA, then a clean frame
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    check("mid_busy", int'(rx_busy), 1);
    ser_in = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_byte",  int'(dout_byte), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_busy",  int'(rx_busy), 0);
    check("mid_rst_fe",    int'(frame_err), 0);
    check("mid_rst_ov",    int'(overrun_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b1, -1);
    idle(4);
    check("post_rst_byte",  int'(dout_byte), 8'h3C);
    check("post_rst_valid", int'(dout_valid), 1);
    check("post_rst_fe",    fe_cnt - fe0, 0);
    check("post_rst_ov",    ov_cnt - ov0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
